// File: rtl/bus_width_downsizer.sv
// rtl/bus_width_downsizer.sv - splits each wide valid/ready word into RATIO narrow beats
module bus_width_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [IN_WIDTH-1:0]  data_i,
  input  logic                 last_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 last_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic                hold_last_q, hold_last_d;
  logic                hold_valid_q, hold_valid_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       slice_idx;
  logic                last_beat, acc_in, acc_out;

  assign last_beat = (cnt_q == LAST_CNT);
  // ready_i feeds ready_o combinationally; the upstream skid stage breaks the loop.
  assign ready_o   = rst_n & (~hold_valid_q | (last_beat & ready_i));
  assign valid_o   = rst_n & hold_valid_q;
  assign last_o    = rst_n & hold_valid_q & hold_last_q & last_beat;
  assign acc_in    = valid_i & ready_o;
  assign acc_out   = valid_o & ready_i;
  assign slice_idx = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
  assign data_o    = hold_q[int'(slice_idx) * OUT_WIDTH +: OUT_WIDTH];

  always_comb begin
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    // A new word wins over retiring the final beat of the previous one.
    if (acc_in) begin
      hold_d       = data_i;
      hold_last_d  = last_i;
      hold_valid_d = 1'b1;
      cnt_d        = '0;
    end else if (acc_out && last_beat) begin
      hold_valid_d = 1'b0;
      cnt_d        = '0;
    end else if (acc_out) begin
      cnt_d        = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      cnt_q        <= cnt_d;
    end
  end

  // Data path register is deliberately left out of reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

endmodule

// File: tb/tb_bus_width_downsizer.sv
// tb/tb_bus_width_downsizer.sv - randomized and directed checks of both beat orders against a beat-queue model
module tb_bus_width_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] data_i;
  logic        last_i;
  logic        ready_i;
  logic        ready0, valid0, last0;
  logic        ready1, valid1, last1;
  logic [7:0]  data0, data1;

  int n_checks = 0;
  int n_fail   = 0;
  int popped   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  always #5 clk = ~clk;

  bus_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready0), .data_i(data_i),
    .last_i(last_i), .valid_o(valid0), .ready_i(ready_i), .data_o(data0), .last_o(last0)
  );

  bus_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready1), .data_i(data_i),
    .last_i(last_i), .valid_o(valid1), .ready_i(ready_i), .data_o(data1), .last_o(last1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the queue model, then advance the model at the edge.
  task automatic cycle(input logic rn, input logic v, input logic [31:0] d, input logic l,
                       input logic r, output logic acc);
    logic exp_valid, exp_ready, acc_out;
    @(negedge clk);
    rst_n = rn; valid_i = v; data_i = d; last_i = l; ready_i = r;
    #1;
    exp_valid = rn && (q0.size() > 0);
    exp_ready = rn && ((q0.size() == 0) || (q0.size() == 1 && r));
    check("valid_lsb", 32'(valid0), 32'(exp_valid));
    check("valid_msb", 32'(valid1), 32'(exp_valid));
    check("ready_lsb", 32'(ready0), 32'(exp_ready));
    check("ready_msb", 32'(ready1), 32'(exp_ready));
    if (exp_valid) begin
      check("data_lsb", 32'(data0), 32'(q0[0][7:0]));
      check("data_msb", 32'(data1), 32'(q1[0][7:0]));
      check("last_lsb", 32'(last0), 32'(q0[0][8]));
      check("last_msb", 32'(last1), 32'(q1[0][8]));
    end else begin
      check("last_lsb_idle", 32'(last0), 32'd0);
      check("last_msb_idle", 32'(last1), 32'd0);
    end
    acc     = v && exp_ready;
    acc_out = exp_valid && r;
    @(posedge clk);
    if (!rn) begin
      q0.delete();
      q1.delete();
    end else begin
      if (acc_out) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        popped++;
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          q0.push_back({l && (i == 3), d[8*i +: 8]});
          q1.push_back({l && (i == 3), d[8*(3-i) +: 8]});
        end
      end
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic r);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, 1'b1, d, l, r, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, r, acc);
  endtask

  initial begin
    logic        acc, v, l, hold_pending, rn;
    logic [31:0] d;
    int          start;
    logic        pat[7];

    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b0;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    cycle(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, acc);
    idle(2, 1'b1);

    // single word, both beat orders at once
    send_word(32'hDDCCBBAA, 1'b1, 1'b1);
    idle(5, 1'b1);

    // back-to-back words, no gap expected
    start = popped;
    send_word(32'h03020100, 1'b0, 1'b1);
    send_word(32'h07060504, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("b2b_beats", 32'(popped - start), 32'd8);

    // ready_i toggling during one word
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    start = popped;
    send_word(32'hDDCCBBAA, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, pat[i], acc);
    check("toggle_beats", 32'(popped - start), 32'd4);
    check("toggle_empty", 32'(q0.size()), 32'd0);

    // reset while beat BB is pending
    send_word(32'hDDCCBBAA, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
    idle(1, 1'b1);
    send_word(32'h44332211, 1'b1, 1'b1);
    idle(5, 1'b1);

    // randomized traffic with occasional resets
    hold_pending = 1'b0;
    d = '0; l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 199) != 0);
      if (!hold_pending) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        l = $urandom_range(0, 1);
      end else begin
        v = 1'b1;
      end
      cycle(rn, v, d, l, ($urandom_range(0, 3) != 0), acc);
      hold_pending = v && !acc && rn;
    end
    idle(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
